duc_iq_interpolator: RTL and testbench
======================================

# duc_iq_interpolator

Baseband I/Q interpolation stage that sits directly upstream of the digital up-converter. It accepts signed 16-bit I/Q sample pairs through a valid/ready handshake and buffers them in a small FIFO. It produces a linearly interpolated stream at L = 2^INTERP_LOG2 times the input rate, which feeds the up-converter's I/Q inputs. It also reports FIFO-empty status and counts underruns.

## Interface

**Parameters**
- DATA_W, 16, signed two's-complement sample width for I and Q.
- INTERP_LOG2, 2, log2 of the interpolation factor (L = 4).
- FIFO_DEPTH, 4, input FIFO entries; power of two, ≥ 2.

**Ports**
- Clocking and reset: one clock; reset is synchronous and active-high.
- sys_clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- s_valid  in  1  input pair valid.
- s_ready  out  1  input accept; equals (fifo count < FIFO_DEPTH), combinational from count.
- s_i, s_q  in  DATA_W  input I/Q sample.
- m_valid  out  1  output pair valid (registered).
- m_ready  in  1  downstream (up-converter) accept.
- m_i, m_q  out  DATA_W  interpolated I/Q sample (registered).
- empty  out  1  FIFO count == 0.
- underrun_cnt  out  8  saturating count of RUN→IDLE transitions.

## Operation

- Input FIFO
  - A push occurs on `s_valid && s_ready`.
  - There is no bypass. When the FIFO is full, s_ready is low even if a pop happens in the same cycle.
  - A simultaneous push and pop leaves the count unchanged.
- Engine registers
  - prev and curr: I/Q pairs.
  - k: phase counter, 0..L-1.
  - State: IDLE or RUN.
- Interpolated value, per channel, combinational:
  - diff = curr − prev, computed at DATA_W+1 bits signed.
  - p = diff·k, at DATA_W+1+INTERP_LOG2 bits.
  - y = prev + (p >>> INTERP_LOG2), using an arithmetic shift (floor).
  - y always lies between prev and curr, so it is truncated to DATA_W with no saturation.
- "out_free" means `!m_valid || m_ready`.
- IDLE
  - If the FIFO is non-empty: pop into curr, set k = 0, go to RUN.
  - prev is unchanged in IDLE.
  - If the output register is free, m_valid ← 0.
- RUN with out_free
  - m_i/m_q ← y, m_valid ← 1, k ← k+1.
  - If k == L−1:
    - prev ← curr.
    - If the FIFO is non-empty: pop into curr, k ← 0, stay in RUN. No bubble.
    - Otherwise: go to IDLE, and underrun_cnt ← min(underrun_cnt+1, 255).
- RUN with !out_free
  - All engine state and outputs hold.
  - m_i/m_q stay stable while m_valid is high and m_ready is low.
- Reset (rst high at an edge, including mid-operation)
  - FIFO is flushed: count 0, pointers 0.
  - prev = curr = 0, k = 0, state IDLE.
  - m_valid = 0, m_i = m_q = 0, underrun_cnt = 0.
  - After reset, s_ready = 1 and empty = 1.

## Timing

- Latency: a sample accepted at edge N is popped into curr at edge N+1. Its first output (k = 0, value prev) is valid after edge N+2.
- Throughput with m_ready held high: one output per cycle, one input consumed per L cycles.
- Each input produces exactly L outputs: prev + (curr−prev)·k/L for k = 0..L−1. The curr value itself is first emitted as k = 0 of the next segment.
- Backpressure: with m_ready low, the engine holds one sample in curr and one in the output register.
  - The FIFO therefore fills after FIFO_DEPTH+1 accepted pairs.
  - s_ready falls in the same cycle the count reaches FIFO_DEPTH.
- FIFO pointers wrap modulo FIFO_DEPTH. The count ranges 0..FIFO_DEPTH.

## Test plan

- Reset check: assert rst for 2 cycles → m_valid = 0, m_i = m_q = 0, s_ready = 1, empty = 1, underrun_cnt = 0.
- Single push after reset, m_ready = 1, I = 0x0400, Q = 0xFC00 → starting 2 cycles after acceptance, outputs I = 0x0000, 0x0100, 0x0200, 0x0300 and Q = 0x0000, 0xFF00, 0xFE00, 0xFD00. Then m_valid falls and underrun_cnt = 1.
- Continuous stream, m_ready = 1, pairs pushed with I = 0x0400 then 0x0800 (the second pair present before the first finishes) → I = 0x0000, 0x0100, 0x0200, 0x0300, 0x0400, 0x0500, 0x0600, 0x0700 with no m_valid gap, then underrun_cnt = 1.
- Floor and extremes
  - prev = 0, curr I = 0xFFFF → 0x0000, 0xFFFF, 0xFFFF, 0xFFFF.
  - Segment with prev I = 0x8000, curr I = 0x7FFF → 0x8000, 0xBFFF, 0xFFFF, 0x3FFF.
- Backpressure: m_ready = 0, s_valid held high from reset → exactly 5 pairs accepted, then s_ready = 0. m_valid = 1 with m_i = 0 held stable. Raising m_ready resumes the output sequence with no samples lost or duplicated.
- Reset mid-stream: assert rst while in RUN with 3 FIFO entries → at the next edge empty = 1, m_valid = 0, and the next accepted sample interpolates from prev = 0.

Source files
------------

// File: rtl/duc_iq_interpolator.sv
// I/Q linear interpolator ahead of the up-converter.
// Input pairs are buffered in a small FIFO. The engine emits L = 2^INTERP_LOG2 outputs
// per input, stepping linearly from the previous sample towards the current one.
module duc_iq_interpolator #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned INTERP_LOG2 = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_i,
    input  logic [DATA_W-1:0] s_q,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_i,
    output logic [DATA_W-1:0] m_q,
    output logic              empty,
    output logic [7:0]        underrun_cnt
);

    localparam int unsigned PW = DATA_W + 1 + INTERP_LOG2;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {StIdle, StRun} state_e;

    // FIFO storage and bookkeeping
    logic [2*DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q;
    logic                push, pop;
    logic [2*DATA_W-1:0] fifo_rd;

    // Engine state
    state_e                 state_q, state_d;
    logic [DATA_W-1:0]      prev_i_q, prev_i_d, prev_q_q, prev_q_d;
    logic [DATA_W-1:0]      curr_i_q, curr_i_d, curr_q_q, curr_q_d;
    logic [INTERP_LOG2-1:0] k_q, k_d;
    logic                   m_valid_q, m_valid_d;
    logic [DATA_W-1:0]      m_i_q, m_i_d, m_q_q, m_q_d;
    logic [7:0]             underrun_q, underrun_d;
    logic                   out_free;
    logic [DATA_W-1:0]      y_i, y_q;

    // prev + floor((curr - prev) * k / L); result always lies between prev and curr
    function automatic logic [DATA_W-1:0] interp(input logic [DATA_W-1:0]      p,
                                                 input logic [DATA_W-1:0]      c,
                                                 input logic [INTERP_LOG2-1:0] k);
        logic signed [PW-1:0] pe, ce, d, kk, prod, y;
        pe   = {{(PW-DATA_W){p[DATA_W-1]}}, p};
        ce   = {{(PW-DATA_W){c[DATA_W-1]}}, c};
        d    = ce - pe;
        kk   = {{(PW-INTERP_LOG2){1'b0}}, k};
        prod = d * kk;
        y    = pe + (prod >>> INTERP_LOG2);
        return y[DATA_W-1:0];
    endfunction

    assign s_ready      = (count_q < CW'(FIFO_DEPTH));
    assign empty        = (count_q == '0);
    assign push         = s_valid && s_ready;
    assign fifo_rd      = mem_q[rd_ptr_q];
    assign out_free     = !m_valid_q || m_ready;
    assign y_i          = interp(prev_i_q, curr_i_q, k_q);
    assign y_q          = interp(prev_q_q, curr_q_q, k_q);
    assign m_valid      = m_valid_q;
    assign m_i          = m_i_q;
    assign m_q          = m_q_q;
    assign underrun_cnt = underrun_q;

    // FIFO data array; contents need no reset since count gates every read
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_i, s_q};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    // Engine and output register state
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q    <= StIdle;
            prev_i_q   <= '0;
            prev_q_q   <= '0;
            curr_i_q   <= '0;
            curr_q_q   <= '0;
            k_q        <= '0;
            m_valid_q  <= 1'b0;
            m_i_q      <= '0;
            m_q_q      <= '0;
            underrun_q <= '0;
        end else begin
            state_q    <= state_d;
            prev_i_q   <= prev_i_d;
            prev_q_q   <= prev_q_d;
            curr_i_q   <= curr_i_d;
            curr_q_q   <= curr_q_d;
            k_q        <= k_d;
            m_valid_q  <= m_valid_d;
            m_i_q      <= m_i_d;
            m_q_q      <= m_q_d;
            underrun_q <= underrun_d;
        end
    end

    // Next-state: load a segment when idle, step the phase while the output is free
    always_comb begin
        state_d    = state_q;
        prev_i_d   = prev_i_q;
        prev_q_d   = prev_q_q;
        curr_i_d   = curr_i_q;
        curr_q_d   = curr_q_q;
        k_d        = k_q;
        m_valid_d  = m_valid_q;
        m_i_d      = m_i_q;
        m_q_d      = m_q_q;
        underrun_d = underrun_q;
        pop        = 1'b0;
        case (state_q)
            StIdle: begin
                if (out_free) m_valid_d = 1'b0;
                if (!empty) begin
                    pop      = 1'b1;
                    curr_i_d = fifo_rd[2*DATA_W-1:DATA_W];
                    curr_q_d = fifo_rd[DATA_W-1:0];
                    k_d      = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (out_free) begin
                    m_i_d     = y_i;
                    m_q_d     = y_q;
                    m_valid_d = 1'b1;
                    k_d       = k_q + INTERP_LOG2'(1);
                    if (k_q == '1) begin
                        prev_i_d = curr_i_q;
                        prev_q_d = curr_q_q;
                        if (!empty) begin
                            // Chain straight into the next segment without a bubble
                            pop      = 1'b1;
                            curr_i_d = fifo_rd[2*DATA_W-1:DATA_W];
                            curr_q_d = fifo_rd[DATA_W-1:0];
                            k_d      = '0;
                        end else begin
                            state_d = StIdle;
                            if (underrun_q != 8'hFF) underrun_d = underrun_q + 8'd1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_duc_iq_interpolator.sv
// Directed bench for duc_iq_interpolator with hand-computed expected sequences.
module tb_duc_iq_interpolator;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_i, s_q;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_i, m_q;
    logic        empty;
    logic [7:0]  underrun_cnt;

    int n_checks = 0;
    int n_errors = 0;

    duc_iq_interpolator #(
        .DATA_W      (16),
        .INTERP_LOG2 (2),
        .FIFO_DEPTH  (4)
    ) dut (
        .sys_clk      (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_i          (s_i),
        .s_q          (s_q),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_i          (m_i),
        .m_q          (m_q),
        .empty        (empty),
        .underrun_cnt (underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Two reset edges, released on a falling edge
    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Present one pair and hold it until accepted (bounded)
    task automatic push(input logic [15:0] vi, input logic [15:0] vq);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        s_valid = 1'b1;
        s_i     = vi;
        s_q     = vq;
        for (int t = 0; t < 20; t++) begin
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("push_accept", 32'(ok), 32'd1);
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    // Wait for the next output handshake and compare it, including how many cycles it took
    task automatic expect_out(input string tag, input logic [15:0] ei, input logic [15:0] eq,
                              input int ewait);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(m_valid && m_ready) && w < 20);
        chk({tag, "_wait"}, 32'(w), 32'(ewait));
        chk({tag, "_i"}, 32'(m_i), 32'(ei));
        chk({tag, "_q"}, 32'(m_q), 32'(eq));
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] ei [8];
        logic [15:0] eq [8];
        logic [15:0] v;
        int          acc;
        bit          rdy;

        rst     = 1'b1;
        s_valid = 1'b0;
        s_i     = '0;
        s_q     = '0;
        m_ready = 1'b1;

        // Reset state
        do_reset();
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_i", 32'(m_i), 32'd0);
        chk("rst_m_q", 32'(m_q), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_underrun", 32'(underrun_cnt), 32'd0);

        // Single push: ramps 0 -> 0x0400 and 0 -> 0xFC00
        push(16'h0400, 16'hFC00);
        expect_out("single0", 16'h0000, 16'h0000, 3);
        expect_out("single1", 16'h0100, 16'hFF00, 1);
        expect_out("single2", 16'h0200, 16'hFE00, 1);
        expect_out("single3", 16'h0300, 16'hFD00, 1);
        @(negedge clk);
        chk("single_end_valid", 32'(m_valid), 32'd0);
        chk("single_underrun", 32'(underrun_cnt), 32'd1);

        // Continuous stream of two pairs, no gap at the segment boundary
        do_reset();
        push(16'h0400, 16'h0000);
        push(16'h0800, 16'h0000);
        for (int n = 0; n < 8; n++) begin
            expect_out("stream", 16'(32'h100 * n), 16'h0000, (n == 0) ? 2 : 1);
        end
        @(negedge clk);
        chk("stream_end_valid", 32'(m_valid), 32'd0);
        chk("stream_underrun", 32'(underrun_cnt), 32'd1);

        // Floor on a negative step of one LSB
        do_reset();
        push(16'hFFFF, 16'h0000);
        expect_out("floor0", 16'h0000, 16'h0000, 3);
        expect_out("floor1", 16'hFFFF, 16'h0000, 1);
        expect_out("floor2", 16'hFFFF, 16'h0000, 1);
        expect_out("floor3", 16'hFFFF, 16'h0000, 1);

        // Full-scale swing between extremes
        do_reset();
        push(16'h8000, 16'h7FFF);
        push(16'h7FFF, 16'h8000);
        ei = '{16'h0000, 16'hE000, 16'hC000, 16'hA000, 16'h8000, 16'hBFFF, 16'hFFFF, 16'h3FFF};
        eq = '{16'h0000, 16'h1FFF, 16'h3FFF, 16'h5FFF, 16'h7FFF, 16'h3FFF, 16'hFFFF, 16'hBFFF};
        for (int n = 0; n < 8; n++) begin
            expect_out("extreme", ei[n], eq[n], (n == 0) ? 2 : 1);
        end

        // Backpressure: s_valid held from reset, downstream stalled
        m_ready = 1'b0;
        do_reset();
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            v       = 16'(32'h400 * (acc + 1));
            s_valid = 1'b1;
            s_i     = v;
            s_q     = 16'h0000 - v;
            rdy     = s_ready;
            @(posedge clk);
            if (rdy) acc++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("bp_accepted", 32'(acc), 32'd5);
        chk("bp_s_ready", 32'(s_ready), 32'd0);
        chk("bp_empty", 32'(empty), 32'd0);
        chk("bp_m_valid", 32'(m_valid), 32'd1);
        chk("bp_m_i", 32'(m_i), 32'd0);
        repeat (3) @(negedge clk);
        chk("bp_hold_i", 32'(m_i), 32'd0);
        chk("bp_hold_valid", 32'(m_valid), 32'd1);
        @(posedge clk);
        #1 m_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            v = 16'(32'h100 * n);
            expect_out("bp_drain", v, 16'h0000 - v, 1);
        end
        @(negedge clk);
        chk("bp_end_valid", 32'(m_valid), 32'd0);
        chk("bp_underrun", 32'(underrun_cnt), 32'd1);

        // Reset while running with three pairs queued
        m_ready = 1'b0;
        do_reset();
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            if (acc == 4) break;
            v       = 16'(32'h1000 * (acc + 1));
            s_valid = 1'b1;
            s_i     = v;
            s_q     = v;
            rdy     = s_ready;
            @(posedge clk);
            if (rdy) acc++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("mid_accepted", 32'(acc), 32'd4);
        chk("mid_pre_empty", 32'(empty), 32'd0);
        chk("mid_pre_valid", 32'(m_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_empty", 32'(empty), 32'd1);
        chk("mid_m_valid", 32'(m_valid), 32'd0);
        chk("mid_s_ready", 32'(s_ready), 32'd1);
        chk("mid_underrun", 32'(underrun_cnt), 32'd0);
        rst     = 1'b0;
        m_ready = 1'b1;
        push(16'h0400, 16'h0400);
        expect_out("mid0", 16'h0000, 16'h0000, 3);
        expect_out("mid1", 16'h0100, 16'h0100, 1);
        expect_out("mid2", 16'h0200, 16'h0200, 1);
        expect_out("mid3", 16'h0300, 16'h0300, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
